// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed 32-bit RAM behind valid/ready request/response channels with LATENCY wait states
//   clock      rising-edge system clock
//   Reset      asynchronous active-low reset
//   req_*      request channel (valid/ready, we, byte addr, wdata, byte enables), accepted only in IDLE
//   rsp_*      response channel (valid/ready, rdata, err), held stable until rsp_ready
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam bit ZERO = LATENCY == 0;
  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "data_mem_responder: LATENCY must be in 0..15");
  end
  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              l_we;
  logic [31:0]       l_addr;
  logic [31:0]       l_wdata;
  logic [3:0]        l_be;
  logic [31:0]       mem [2**ADDR_W];
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic [ADDR_W-1:0] idx;
  logic              err;
  logic              do_access;
  // With no wait states the access happens on the accept edge, straight from the request inputs;
  // otherwise it uses the request latched at accept. Gating with Reset keeps a reset from ever writing.
  always_comb begin
    acc_we    = ZERO ? req_we    : l_we;
    acc_addr  = ZERO ? req_addr  : l_addr;
    acc_wdata = ZERO ? req_wdata : l_wdata;
    acc_be    = ZERO ? req_be    : l_be;
    idx       = acc_addr[ADDR_W+1:2];
    err       = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);
    do_access = Reset && (ZERO ? (state == IDLE && req_valid) : (state == WAIT && cnt == 4'd1));
  end
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      l_we      <= 1'b0;
      l_addr    <= '0;
      l_wdata   <= '0;
      l_be      <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        state   <= ZERO ? RESP : WAIT;
        cnt     <= 4'(LATENCY);
        l_we    <= req_we;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
        l_be    <= req_be;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= RESP;
      end else if (state == RESP && rsp_ready) begin
        state     <= IDLE;
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
      if (do_access) begin
        rsp_err   <= err;
        rsp_rdata <= (err || acc_we) ? '0 : mem[idx];
      end
    end
  end
  // Storage is not reset; only enabled byte lanes of a legal store are written.
  always_ff @(posedge clock) begin
    if (do_access && acc_we && !err)
      for (int i = 0; i < 4; i++)
        if (acc_be[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
  end
endmodule
